cp0_exc_ctrl: RTL and testbench

Parametrised coprocessor-0 exception controller for the pipelined MIPS core, replacing the single stand-alone Status register. It holds Status (12), Cause (13) and EPC (14) and arbitrates synchronous exceptions, hardware/software interrupts and `eret`. It produces a registered one-cycle redirect to the fetch stage. It sits beside the MEM/WB boundary, where exceptions are committed.

---
 rtl/cp0_pkg.sv | 38 +++
 rtl/irq_sync.sv | 28 ++
 rtl/cp0_exc_ctrl.sv | 147 ++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, ExcCodes, field positions and event encoding
package cp0_pkg;

    // CP0 register numbers
    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Status bit positions
    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 8;

    // Cause bit positions
    localparam int CA_EXC_LO   = 2;
    localparam int CA_IP_SW_LO = 8;
    localparam int CA_IP_HW_LO = 10;
    localparam int CA_BD       = 31;

    // The single event that acts in a given cycle, after priority resolution
    typedef enum logic [2:0] {
        EV_NONE,
        EV_EXC,
        EV_IRQ,
        EV_ERET,
        EV_MTC0
    } cp0_event_e;

endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - parametrised width/depth flop-chain synchroniser
//   clk, rst : clock, synchronous active-high reset (clears every stage)
//   d        : asynchronous input lines
//   q        : synchronised lines, DEPTH edges after d
module irq_sync #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 Status/Cause/EPC and exception/interrupt/eret arbitration
//   clk, rst                       : clock, synchronous active-high reset
//   mtc0_we/addr/data              : register write from WB
//   mfc0_addr, mfc0_data           : combinational register read (0 for unimplemented)
//   hw_irq                         : asynchronous level interrupt lines
//   exc_req/code/pc/bd             : committed synchronous exception
//   eret                           : committed eret
//   flush, redirect_valid/pc       : registered one-cycle redirect to fetch
//   status_q, cause_q, epc_q       : current register values
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_HW_IRQ  = 6,
    parameter logic [31:0] STATUS_RST  = 32'h0000_FF01,
    parameter logic [31:0] EXC_VECTOR  = 32'h8000_0180,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mtc0_we,
    input  logic [4:0]            mtc0_addr,
    input  logic [31:0]           mtc0_data,
    input  logic [4:0]            mfc0_addr,
    output logic [31:0]           mfc0_data,
    input  logic [NUM_HW_IRQ-1:0] hw_irq,
    input  logic                  exc_req,
    input  logic [4:0]            exc_code,
    input  logic [31:0]           exc_pc,
    input  logic                  exc_bd,
    input  logic                  eret,
    output logic                  flush,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc,
    output logic [31:0]           status_q,
    output logic [31:0]           cause_q,
    output logic [31:0]           epc_q
);

    // Architectural state, kept as individual fields
    logic [7:0]            im_r;
    logic                  exl_r;
    logic                  ie_r;
    logic                  bd_r;
    logic [4:0]            exc_code_r;
    logic [1:0]            ip_sw_r;
    logic [31:0]           epc_r;
    logic [NUM_HW_IRQ-1:0] hw_sync;
    logic [5:0]            ip_hw;
    logic [7:0]            ip_all;
    logic                  irq_pend;
    cp0_event_e            ev;

    // The synchroniser output is itself Cause.IP[15:10]; no extra register,
    // so the interrupt reaches IP after exactly SYNC_STAGES edges.
    irq_sync #(
        .WIDTH (NUM_HW_IRQ),
        .DEPTH (SYNC_STAGES)
    ) u_irq_sync (
        .clk (clk),
        .rst (rst),
        .d   (hw_irq),
        .q   (hw_sync)
    );

    always_comb begin
        ip_hw                 = '0;
        ip_hw[NUM_HW_IRQ-1:0] = hw_sync;
    end

    assign ip_all   = {ip_hw, ip_sw_r};
    assign irq_pend = ie_r & ~exl_r & (|(ip_all & im_r));

    assign status_q = {16'b0, im_r, 6'b0, exl_r, ie_r};
    assign cause_q  = {bd_r, 15'b0, ip_hw, ip_sw_r, 1'b0, exc_code_r, 2'b0};
    assign epc_q    = epc_r;

    always_comb begin
        case (mfc0_addr)
            CP0_STATUS: mfc0_data = status_q;
            CP0_CAUSE:  mfc0_data = cause_q;
            CP0_EPC:    mfc0_data = epc_q;
            default:    mfc0_data = 32'b0;
        endcase
    end

    // One event per cycle; anything of lower priority is dropped and the
    // pipeline flush re-executes it.
    always_comb begin
        ev = EV_NONE;
        if (exc_req)       ev = EV_EXC;
        else if (irq_pend) ev = EV_IRQ;
        else if (eret)     ev = EV_ERET;
        else if (mtc0_we)  ev = EV_MTC0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            im_r           <= STATUS_RST[ST_IM_LO +: 8];
            exl_r          <= STATUS_RST[ST_EXL];
            ie_r           <= STATUS_RST[ST_IE];
            bd_r           <= 1'b0;
            exc_code_r     <= 5'd0;
            ip_sw_r        <= 2'b0;
            epc_r          <= 32'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'b0;
            flush          <= 1'b0;
        end else begin
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
            case (ev)
                EV_EXC, EV_IRQ: begin
                    // Nested entry (EXL already set) keeps the original EPC/BD
                    if (!exl_r) begin
                        epc_r <= exc_pc;
                        bd_r  <= exc_bd;
                    end
                    exc_code_r     <= (ev == EV_EXC) ? exc_code : EXC_INT;
                    exl_r          <= 1'b1;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= EXC_VECTOR;
                    flush          <= 1'b1;
                end
                EV_ERET: begin
                    exl_r          <= 1'b0;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= epc_r;
                    flush          <= 1'b1;
                end
                EV_MTC0: begin
                    case (mtc0_addr)
                        CP0_STATUS: begin
                            im_r  <= mtc0_data[ST_IM_LO +: 8];
                            exl_r <= mtc0_data[ST_EXL];
                            ie_r  <= mtc0_data[ST_IE];
                        end
                        CP0_CAUSE: ip_sw_r <= mtc0_data[CA_IP_SW_LO +: 2];
                        CP0_EPC:   epc_r   <= mtc0_data;
                        default:   ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - directed self-checking bench for cp0_exc_ctrl
module tb_cp0_exc_ctrl;

    logic        clk;
    logic        rst;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_data;
    logic [4:0]  mfc0_addr;
    logic [31:0] mfc0_data;
    logic [5:0]  hw_irq;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic        eret;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] status_q;
    logic [31:0] cause_q;
    logic [31:0] epc_q;

    int n_checks = 0;
    int n_errors = 0;
    int rv_seen;

    localparam logic [31:0] VEC = 32'h8000_0180;

    cp0_exc_ctrl #(
        .NUM_HW_IRQ  (6),
        .STATUS_RST  (32'h0000_FF01),
        .EXC_VECTOR  (VEC),
        .SYNC_STAGES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mtc0_we        (mtc0_we),
        .mtc0_addr      (mtc0_addr),
        .mtc0_data      (mtc0_data),
        .mfc0_addr      (mfc0_addr),
        .mfc0_data      (mfc0_data),
        .hw_irq         (hw_irq),
        .exc_req        (exc_req),
        .exc_code       (exc_code),
        .exc_pc         (exc_pc),
        .exc_bd         (exc_bd),
        .eret           (eret),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .status_q       (status_q),
        .cause_q        (cause_q),
        .epc_q          (epc_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mtc0_we   = 1'b0;
        mtc0_addr = 5'd0;
        mtc0_data = 32'd0;
        exc_req   = 1'b0;
        exc_code  = 5'd0;
        exc_pc    = 32'd0;
        exc_bd    = 1'b0;
        eret      = 1'b0;
    endtask

    task automatic do_mtc0(input logic [4:0] a, input logic [31:0] d);
        mtc0_we   = 1'b1;
        mtc0_addr = a;
        mtc0_data = d;
        tick();
        idle_inputs();
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        mfc0_addr = a;
        #1;
        check(tag, mfc0_data, exp);
    endtask

    initial begin
        rst       = 1'b1;
        hw_irq    = 6'd0;
        mfc0_addr = 5'd0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        rd("rst_status", 5'd12, 32'h0000_FF01);
        rd("rst_cause",  5'd13, 32'h0000_0000);
        rd("rst_epc",    5'd14, 32'h0000_0000);
        check("rst_rv",    {31'b0, redirect_valid}, 32'd0);
        check("rst_flush", {31'b0, flush},          32'd0);
        check("rst_rpc",   redirect_pc,             32'd0);

        // Status write masks unimplemented bits; unimplemented reg reads 0
        do_mtc0(5'd12, 32'hFFFF_FFFF);
        rd("status_mask", 5'd12, 32'h0000_FF03);
        rd("reg20_zero",  5'd20, 32'h0000_0000);

        // Back to NORMAL with IE=1, IM=all
        do_mtc0(5'd12, 32'h0000_FF01);
        check("status_normal", status_q, 32'h0000_FF01);

        // Synchronous exception, delay slot
        exc_req = 1'b1; exc_code = 5'd12; exc_pc = 32'h0040_0010; exc_bd = 1'b1;
        tick();
        idle_inputs();
        check("exc_rv",     {31'b0, redirect_valid}, 32'd1);
        check("exc_flush",  {31'b0, flush},          32'd1);
        check("exc_rpc",    redirect_pc,             VEC);
        check("exc_epc",    epc_q,                   32'h0040_0010);
        check("exc_cause",  cause_q,                 32'h8000_0030);
        check("exc_status", status_q,                32'h0000_FF03);
        tick();
        check("exc_rv_drop",    {31'b0, redirect_valid}, 32'd0);
        check("exc_flush_drop", {31'b0, flush},          32'd0);

        // Nested exception: EPC and BD kept, ExcCode updated
        exc_req = 1'b1; exc_code = 5'd4; exc_pc = 32'h0040_0050; exc_bd = 1'b0;
        tick();
        idle_inputs();
        check("nest_rv",    {31'b0, redirect_valid}, 32'd1);
        check("nest_epc",   epc_q,                   32'h0040_0010);
        check("nest_cause", cause_q,                 32'h8000_0010);

        // eret back to EPC
        eret = 1'b1;
        tick();
        idle_inputs();
        check("eret1_rv",     {31'b0, redirect_valid}, 32'd1);
        check("eret1_rpc",    redirect_pc,             32'h0040_0010);
        check("eret1_status", status_q,                32'h0000_FF01);

        // Hardware interrupt with IM[10] only: 3 edges to redirect
        do_mtc0(5'd12, 32'h0000_0401);
        hw_irq = 6'b000001;
        exc_pc = 32'h0040_0080;
        tick();
        check("irq_e1_rv", {31'b0, redirect_valid}, 32'd0);
        tick();
        check("irq_e2_rv", {31'b0, redirect_valid}, 32'd0);
        check("irq_e2_ip", {31'b0, cause_q[10]},    32'd1);
        tick();
        check("irq_e3_rv",     {31'b0, redirect_valid}, 32'd1);
        check("irq_e3_rpc",    redirect_pc,             VEC);
        check("irq_e3_cause",  cause_q,                 32'h0000_0400);
        check("irq_e3_epc",    epc_q,                   32'h0040_0080);
        check("irq_e3_status", status_q,                32'h0000_0403);
        tick();
        check("irq_masked_exl", {31'b0, redirect_valid}, 32'd0);

        // IM[10]=0: interrupt line high but no redirect
        idle_inputs();
        do_mtc0(5'd12, 32'h0000_0001);
        rv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (redirect_valid) rv_seen++;
            tick();
        end
        check("irq_im0_no_rv", rv_seen, 32'd0);
        hw_irq = 6'd0;
        tick();
        tick();
        tick();
        check("irq_ip_clear", cause_q, 32'h0000_0400 & 32'h0);

        // exc_req + eret + mtc0 EPC together: only the exception acts
        exc_req = 1'b1; exc_code = 5'd8; exc_pc = 32'h0040_0200; exc_bd = 1'b0;
        eret = 1'b1;
        mtc0_we = 1'b1; mtc0_addr = 5'd14; mtc0_data = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        check("prio_rv",     {31'b0, redirect_valid}, 32'd1);
        check("prio_rpc",    redirect_pc,             VEC);
        check("prio_epc",    epc_q,                   32'h0040_0200);
        check("prio_cause",  cause_q,                 32'h0000_0020);
        check("prio_status", status_q,                32'h0000_0003);

        // eret to a software-written EPC
        do_mtc0(5'd14, 32'h0040_0100);
        rd("epc_wr", 5'd14, 32'h0040_0100);
        eret = 1'b1;
        tick();
        idle_inputs();
        check("eret2_rv",     {31'b0, redirect_valid}, 32'd1);
        check("eret2_flush",  {31'b0, flush},          32'd1);
        check("eret2_rpc",    redirect_pc,             32'h0040_0100);
        check("eret2_status", status_q,                32'h0000_0001);
        tick();
        check("eret2_flush_drop", {31'b0, flush}, 32'd0);

        // Redirect pending, then reset: cancelled, reset values next edge
        exc_req = 1'b1; exc_code = 5'd10; exc_pc = 32'h0040_0300;
        tick();
        idle_inputs();
        check("pre_rst_rv", {31'b0, redirect_valid}, 32'd1);
        rst = 1'b1;
        exc_req = 1'b1;
        tick();
        idle_inputs();
        check("mid_rst_rv",     {31'b0, redirect_valid}, 32'd0);
        check("mid_rst_rpc",    redirect_pc,             32'd0);
        check("mid_rst_status", status_q,                32'h0000_FF01);
        check("mid_rst_epc",    epc_q,                   32'd0);
        rst = 1'b0;

        // Cause write: only IP[9:8] stick; software IRQ fires next cycle
        exc_pc = 32'h0040_0400;
        mtc0_we = 1'b1; mtc0_addr = 5'd13; mtc0_data = 32'hFFFF_FFFF;
        tick();
        mtc0_we = 1'b0;
        check("cause_sw_wr", cause_q, 32'h0000_0300);
        check("sw_irq_e0",   {31'b0, redirect_valid}, 32'd0);
        tick();
        idle_inputs();
        check("sw_irq_rv",  {31'b0, redirect_valid}, 32'd1);
        check("sw_irq_epc", epc_q,                   32'h0040_0400);
        check("sw_irq_st",  status_q,                32'h0000_FF03);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
